// File: rtl/fwrisc_bus_arb.sv
// N-port memory-bus arbiter: merges fwrisc instruction/data buses (plus optional
// extra masters) onto one memory port using fixed-priority or round-robin selection.
module fwrisc_bus_arb #(
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_PORTS-1:0]               m_valid,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]    m_addr,
  input  logic [N_PORTS*DATA_WIDTH-1:0]    m_wdata,
  input  logic [N_PORTS*DATA_WIDTH/8-1:0]  m_wstb,
  input  logic [N_PORTS-1:0]               m_write,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic [N_PORTS-1:0]               m_ready,
  output logic                             s_valid,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  output logic [DATA_WIDTH/8-1:0]          s_wstb,
  output logic                             s_write,
  input  logic [DATA_WIDTH-1:0]            s_rdata,
  input  logic                             s_ready
);

  localparam int unsigned STB_WIDTH   = DATA_WIDTH / 8;
  localparam int unsigned GRANT_WIDTH = (N_PORTS > 2) ? $clog2(N_PORTS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state;
  logic [GRANT_WIDTH-1:0] grant;
  logic [GRANT_WIDTH-1:0] last;
  logic [GRANT_WIDTH-1:0] winner;
  logic                   any_req;

  // Winner search: from index 0 (fixed priority) or from last+1 with wrap (round-robin).
  always_comb begin : pick_winner
    int unsigned idx;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (ARB_MODE == 1) begin
        idx = (32'(last) + 32'd1 + k) % N_PORTS;
      end else begin
        idx = k;
      end
      if (!any_req && m_valid[GRANT_WIDTH'(idx)]) begin
        winner  = GRANT_WIDTH'(idx);
        any_req = 1'b1;
      end
    end
  end

  // Grant is held until the memory completes; a dropped m_valid never aborts it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      last  <= GRANT_WIDTH'(N_PORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= winner;
            last  <= winner;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (s_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Memory-side mux and completion steering; idle outputs are driven to zero.
  always_comb begin : drive_ports
    s_valid = (state == BUSY);
    s_addr  = '0;
    s_wdata = '0;
    s_wstb  = '0;
    s_write = 1'b0;
    m_ready = '0;
    m_rdata = s_rdata;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (state == BUSY && grant == GRANT_WIDTH'(i)) begin
        s_addr     = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_wdata    = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        s_wstb     = m_wstb[i*STB_WIDTH +: STB_WIDTH];
        s_write    = m_write[i];
        m_ready[i] = s_ready;
      end
    end
  end

endmodule

// File: tb/tb_fwrisc_bus_arb.sv
// Directed bench for fwrisc_bus_arb: a 2-port fixed-priority instance and a
// 4-port round-robin instance sharing clock and reset.
module tb_fwrisc_bus_arb;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [1:0]   v0 = '0, w0 = '0, mr0;
  logic [63:0]  a0 = '0, d0 = '0;
  logic [7:0]   st0 = '0;
  logic [31:0]  mrd0, sa0, swd0, srd0 = '0;
  logic [3:0]   sstb0;
  logic         sv0, sw0, srdy0 = 1'b0;

  logic [3:0]   v1 = '0, w1 = '0, mr1;
  logic [127:0] a1 = '0, d1 = '0;
  logic [15:0]  st1 = '0;
  logic [31:0]  mrd1, sa1, swd1, srd1 = '0;
  logic [3:0]   sstb1;
  logic         sv1, sw1, srdy1 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fwrisc_bus_arb #(.N_PORTS(2), .ARB_MODE(0), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut0 (
    .clock(clock), .reset(reset),
    .m_valid(v0), .m_addr(a0), .m_wdata(d0), .m_wstb(st0), .m_write(w0),
    .m_rdata(mrd0), .m_ready(mr0),
    .s_valid(sv0), .s_addr(sa0), .s_wdata(swd0), .s_wstb(sstb0), .s_write(sw0),
    .s_rdata(srd0), .s_ready(srdy0)
  );

  fwrisc_bus_arb #(.N_PORTS(4), .ARB_MODE(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut1 (
    .clock(clock), .reset(reset),
    .m_valid(v1), .m_addr(a1), .m_wdata(d1), .m_wstb(st1), .m_write(w1),
    .m_rdata(mrd1), .m_ready(mr1),
    .s_valid(sv1), .s_addr(sa1), .s_wdata(swd1), .s_wstb(sstb1), .s_write(sw1),
    .s_rdata(srd1), .s_ready(srdy1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int p;
    int cnt[4];
    int order[6];
    int exp_fp[6];
    int exp_rr[6];
    exp_fp = '{0, 0, 0, 1, 1, 1};
    exp_rr = '{0, 1, 2, 3, 0, 1};

    // reset state
    repeat (2) tick();
    chk("rst_svalid0", 64'(sv0), 64'(0));
    chk("rst_mready0", 64'(mr0), 64'(0));
    chk("rst_swrite0", 64'(sw0), 64'(0));
    chk("rst_swstb0", 64'(sstb0), 64'(0));
    chk("rst_svalid1", 64'(sv1), 64'(0));
    chk("rst_mready1", 64'(mr1), 64'(0));
    reset = 1'b0;
    tick();

    // single zero-wait read from port 1
    v0 = 2'b10; w0 = 2'b00; a0 = {32'h0000_0100, 32'h0};
    srdy0 = 1'b1; srd0 = 32'hDEAD_BEEF;
    #1;
    chk("rd_idle_svalid", 64'(sv0), 64'(0));
    chk("rd_idle_mready", 64'(mr0), 64'(0));
    tick();
    chk("rd_svalid", 64'(sv0), 64'(1));
    chk("rd_saddr", 64'(sa0), 64'h100);
    chk("rd_swrite", 64'(sw0), 64'(0));
    chk("rd_mready", 64'(mr0), 64'(2'b10));
    chk("rd_mrdata", 64'(mrd0), 64'hDEAD_BEEF);
    v0 = 2'b00;
    tick();
    chk("rd_back_idle", 64'(sv0), 64'(0));
    srdy0 = 1'b0;

    // write from port 0 with three wait states
    v0 = 2'b01; w0 = 2'b01; a0 = {32'h0, 32'h40};
    d0 = {32'h0, 32'h1234_5678}; st0 = {4'h0, 4'h3};
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) begin
        srdy0 = 1'b1;
        #1;
      end
      chk($sformatf("wr_svalid_c%0d", c), 64'(sv0), 64'(1));
      chk($sformatf("wr_saddr_c%0d", c), 64'(sa0), 64'h40);
      chk($sformatf("wr_swdata_c%0d", c), 64'(swd0), 64'h1234_5678);
      chk($sformatf("wr_swstb_c%0d", c), 64'(sstb0), 64'h3);
      chk($sformatf("wr_swrite_c%0d", c), 64'(sw0), 64'(1));
      chk($sformatf("wr_mready_c%0d", c), 64'(mr0), (c == 4) ? 64'(1) : 64'(0));
    end
    v0 = 2'b00;
    tick();
    chk("wr_back_idle", 64'(sv0), 64'(0));
    srdy0 = 1'b0; w0 = 2'b00; d0 = '0; st0 = '0;

    // fixed-priority contention, three transfers per port
    v0 = 2'b11; a0 = {32'h204, 32'h104}; srdy0 = 1'b1;
    cnt[0] = 3; cnt[1] = 3; n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      tick();
      if (mr0 != 2'b00) begin
        p = oh_idx(4'(mr0));
        if (n < 6) order[n] = p;
        n++;
        if (p >= 0) begin
          chk($sformatf("fp_saddr%0d", n), 64'(sa0), (p == 0) ? 64'h104 : 64'h204);
          cnt[p]--;
          if (cnt[p] == 0) v0 = v0 & ~mr0;
        end
      end
    end
    chk("fp_count", 64'(n), 64'(6));
    for (int k = 0; k < 6; k++) chk($sformatf("fp_order%0d", k), 64'(order[k]), 64'(exp_fp[k]));
    v0 = 2'b00;
    tick();
    srdy0 = 1'b0;

    // round-robin, four ports, wraps from 3 back to 0
    v1 = 4'hF; srdy1 = 1'b1; srd1 = 32'hCAFE_F00D;
    a1 = {32'h1030, 32'h1020, 32'h1010, 32'h1000};
    cnt[0] = 2; cnt[1] = 2; cnt[2] = 1; cnt[3] = 1; n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      tick();
      if (mr1 != 4'b0000) begin
        p = oh_idx(mr1);
        if (n < 6) order[n] = p;
        n++;
        if (p >= 0) begin
          chk($sformatf("rr_saddr%0d", n), 64'(sa1), 64'(32'h1000 + 32'(p) * 32'h10));
          cnt[p]--;
          if (cnt[p] == 0) v1 = v1 & ~mr1;
        end
      end
    end
    chk("rr_count", 64'(n), 64'(6));
    for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), 64'(order[k]), 64'(exp_rr[k]));
    chk("rr_mrdata", 64'(mrd1), 64'hCAFE_F00D);
    v1 = 4'h0;
    tick();
    srdy1 = 1'b0;

    // reset while port 1 is granted and waiting
    v0 = 2'b10; a0 = {32'h200, 32'h0}; srdy0 = 1'b0;
    tick();
    chk("mrst_svalid_busy", 64'(sv0), 64'(1));
    chk("mrst_saddr_busy", 64'(sa0), 64'h200);
    srdy0 = 1'b1;
    reset = 1'b1;
    #1;
    chk("mrst_svalid", 64'(sv0), 64'(0));
    chk("mrst_mready", 64'(mr0), 64'(0));
    srdy0 = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_idle_after", 64'(sv0), 64'(0));
    tick();
    chk("mrst_regrant_svalid", 64'(sv0), 64'(1));
    chk("mrst_regrant_saddr", 64'(sa0), 64'h200);
    srdy0 = 1'b1;
    #1;
    chk("mrst_regrant_mready", 64'(mr0), 64'(2'b10));
    v0 = 2'b00;
    tick();
    srdy0 = 1'b0;
    chk("mrst_done_idle", 64'(sv0), 64'(0));

    // round-robin restarts at port 0 after reset
    v1 = 4'hF; srdy1 = 1'b1; w1 = 4'h1; d1 = {96'h0, 32'h55}; st1 = {12'h0, 4'hF};
    p = -2;
    for (int c = 0; c < 10 && p == -2; c++) begin
      tick();
      if (mr1 != 4'b0000) begin
        p = oh_idx(mr1);
        chk("rr_rst_swdata", 64'(swd1), 64'h55);
        chk("rr_rst_swstb", 64'(sstb1), 64'hF);
        chk("rr_rst_swrite", 64'(sw1), 64'(1));
      end
    end
    chk("rr_rst_first", 64'(p), 64'(0));
    v1 = 4'h0;
    tick();
    srdy1 = 1'b0; w1 = 4'h0;

    // spurious s_ready while idle
    v0 = 2'b00; srdy0 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("spur_mready%0d", c), 64'(mr0), 64'(0));
      chk($sformatf("spur_svalid%0d", c), 64'(sv0), 64'(0));
      chk($sformatf("spur_saddr%0d", c), 64'(sa0), 64'(0));
      chk($sformatf("spur_swstb%0d", c), 64'(sstb0), 64'(0));
    end
    srdy0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
